// File: rtl/target_game_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : target_game_ctrl                                             |
// | Description : Whack-a-cell game controller: latches a 4x4-grid target per  |
// |               generator period, scores hits/misses, tracks lives and level.|
// |               Optional macro STREAK_BONUS_EN: every 4th straight hit +2.   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module target_game_ctrl #(
    parameter int LIVES_INIT = 3,
    parameter int LEVEL_STEP = 8,
    parameter int MAX_LEVEL  = 5,
    parameter int RAND_DLY   = 2
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [27:0] nanos,
    input  logic [3:0]  rand_cell,
    input  logic        start,
    input  logic        btn_hit,
    input  logic [3:0]  btn_cell,
    output logic [2:0]  nivel,
    output logic [3:0]  target,
    output logic        target_vld,
    output logic [7:0]  score,
    output logic [1:0]  lives,
    output logic [1:0]  state,
    output logic        hit_pulse,
    output logic        miss_pulse
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PLAY = 2'b01,
        S_OVER = 2'b10
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [27:0]         r_nanos_q;
    logic [RAND_DLY-1:0] r_dly;
    logic [7:0]          r_score, w_score_nxt;
    logic [1:0]          r_lives, w_lives_nxt;
    logic [2:0]          r_nivel, w_nivel_nxt;
    logic [3:0]          r_target, w_target_nxt;
    logic                r_vld, w_vld_nxt;
    logic                r_hitp, w_hitp_nxt;
    logic                r_missp, w_missp_nxt;
    logic                w_wrap, w_sample, w_hit, w_miss, w_timeout;
    logic [1:0]          w_inc;
    logic [8:0]          w_sum;
    int                  w_lvl;
`ifdef STREAK_BONUS_EN
    logic [2:0]          r_streak, w_streak_nxt;
`endif

    assign w_wrap    = (nanos == 28'd0) && (r_nanos_q != 28'd0);
    assign w_sample  = r_dly[RAND_DLY-1];
    assign w_hit     = btn_hit && r_vld && (btn_cell == r_target);
    // A correct hit on the wrap cycle pre-empts the timeout; a wrong cell plus wrap costs one life.
    assign w_timeout = w_wrap && r_vld && !w_hit;
    assign w_miss    = (btn_hit && r_vld && !w_hit) || w_timeout;

    generate
        if (RAND_DLY == 1) begin : g_dly_one
            always_ff @(posedge CLK) begin
                if (!reset) r_dly <= '0;
                else        r_dly <= w_wrap;
            end
        end else begin : g_dly_multi
            always_ff @(posedge CLK) begin
                if (!reset) r_dly <= '0;
                else        r_dly <= {r_dly[RAND_DLY-2:0], w_wrap};
            end
        end
    endgenerate

    always_comb begin
        w_state_nxt  = r_state;
        w_score_nxt  = r_score;
        w_lives_nxt  = r_lives;
        w_nivel_nxt  = r_nivel;
        w_target_nxt = r_target;
        w_vld_nxt    = r_vld;
        w_hitp_nxt   = 1'b0;
        w_missp_nxt  = 1'b0;
        w_inc        = 2'd1;
        w_sum        = {1'b0, r_score} + {7'd0, w_inc};
        w_lvl        = 1 + int'(r_score) / LEVEL_STEP;
        if (w_lvl > MAX_LEVEL) w_lvl = MAX_LEVEL;
`ifdef STREAK_BONUS_EN
        w_streak_nxt = r_streak;
`endif
        case (r_state)
            S_IDLE, S_OVER: begin
                if (start) begin
                    w_state_nxt = S_PLAY;
                    w_score_nxt = 8'd0;
                    w_lives_nxt = 2'(LIVES_INIT);
                    w_nivel_nxt = 3'd1;
                    w_vld_nxt   = 1'b0;
`ifdef STREAK_BONUS_EN
                    w_streak_nxt = 3'd0;
`endif
                end
            end
            S_PLAY: begin
                w_nivel_nxt = 3'(w_lvl);
                if (w_hit) begin
`ifdef STREAK_BONUS_EN
                    if (r_streak == 3'd3) begin
                        w_inc        = 2'd2;
                        w_streak_nxt = 3'd0;
                    end else begin
                        w_streak_nxt = r_streak + 3'd1;
                    end
`endif
                    w_sum       = {1'b0, r_score} + {7'd0, w_inc};
                    w_score_nxt = w_sum[8] ? 8'hFF : w_sum[7:0];
                    w_hitp_nxt  = 1'b1;
                    w_vld_nxt   = 1'b0;
                end
                if (w_miss) begin
                    w_lives_nxt = r_lives - 2'd1;
                    w_missp_nxt = 1'b1;
                    if (w_timeout) w_vld_nxt = 1'b0;
`ifdef STREAK_BONUS_EN
                    w_streak_nxt = 3'd0;
`endif
                end
                // A fresh sample loads after the hit has been judged against the old target.
                if (w_sample) begin
                    w_target_nxt = rand_cell;
                    w_vld_nxt    = 1'b1;
                end
                if (w_miss && (r_lives == 2'd1)) begin
                    w_state_nxt = S_OVER;
                    w_vld_nxt   = 1'b0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_nanos_q <= 28'd0;
            r_score   <= 8'd0;
            r_lives   <= 2'd0;
            r_nivel   <= 3'd1;
            r_target  <= 4'd0;
            r_vld     <= 1'b0;
            r_hitp    <= 1'b0;
            r_missp   <= 1'b0;
`ifdef STREAK_BONUS_EN
            r_streak  <= 3'd0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_nanos_q <= nanos;
            r_score   <= w_score_nxt;
            r_lives   <= w_lives_nxt;
            r_nivel   <= w_nivel_nxt;
            r_target  <= w_target_nxt;
            r_vld     <= w_vld_nxt;
            r_hitp    <= w_hitp_nxt;
            r_missp   <= w_missp_nxt;
`ifdef STREAK_BONUS_EN
            r_streak  <= w_streak_nxt;
`endif
        end
    end

    assign nivel      = r_nivel;
    assign target     = r_target;
    assign target_vld = r_vld;
    assign score      = r_score;
    assign lives      = r_lives;
    assign state      = r_state;
    assign hit_pulse  = r_hitp;
    assign miss_pulse = r_missp;

endmodule
`default_nettype wire

// File: tb/tb_target_game_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_target_game_ctrl                                          |
// | Description : Directed bench for target_game_ctrl with a rule-level model  |
// |               compared every cycle. Honours macro STREAK_BONUS_EN.         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_target_game_ctrl;

    localparam int LIVES_INIT = 3;
    localparam int LEVEL_STEP = 8;
    localparam int MAX_LEVEL  = 5;
    localparam int RAND_DLY   = 2;

    logic        CLK = 1'b0;
    logic        reset;
    logic [27:0] nanos;
    logic [3:0]  rand_cell;
    logic        start;
    logic        btn_hit;
    logic [3:0]  btn_cell;
    logic [2:0]  nivel;
    logic [3:0]  target;
    logic        target_vld;
    logic [7:0]  score;
    logic [1:0]  lives;
    logic [1:0]  state;
    logic        hit_pulse;
    logic        miss_pulse;

    target_game_ctrl #(
        .LIVES_INIT(LIVES_INIT), .LEVEL_STEP(LEVEL_STEP),
        .MAX_LEVEL(MAX_LEVEL), .RAND_DLY(RAND_DLY)
    ) dut (
        .CLK(CLK), .reset(reset), .nanos(nanos), .rand_cell(rand_cell),
        .start(start), .btn_hit(btn_hit), .btn_cell(btn_cell),
        .nivel(nivel), .target(target), .target_vld(target_vld),
        .score(score), .lives(lives), .state(state),
        .hit_pulse(hit_pulse), .miss_pulse(miss_pulse)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 0;

    // Rule-level model: game state as plain integers, wrap history as a queue of cycle stamps.
    int          cyc = 0;
    int          wq[$];
    logic [27:0] m_prev = '0;
    int m_state = 0, m_score = 0, m_lives = 0, m_nivel = 1, m_target = 0;
    int m_vld = 0, m_hitp = 0, m_missp = 0, m_streak = 0;

    always @(posedge CLK) begin
        bit wrap, smp, hit, miss;
        int inc, lv;
        cyc++;
        if (!reset) begin
            m_state = 0; m_score = 0; m_lives = 0; m_nivel = 1; m_target = 0;
            m_vld = 0; m_hitp = 0; m_missp = 0; m_streak = 0; m_prev = '0;
            wq.delete();
        end else begin
            wrap = (nanos == 28'd0) && (m_prev != 28'd0);
            smp  = (wq.size() > 0) && (wq[0] + RAND_DLY == cyc);
            if (smp) void'(wq.pop_front());
            if (wrap) wq.push_back(cyc);
            m_prev  = nanos;
            m_hitp  = 0;
            m_missp = 0;
            if (m_state == 1) begin
                lv = 1 + m_score / LEVEL_STEP;
                m_nivel = (lv > MAX_LEVEL) ? MAX_LEVEL : lv;
                hit  = btn_hit && (m_vld != 0) && (int'(btn_cell) == m_target);
                miss = (m_vld != 0) && !hit && (btn_hit || wrap);
                if (hit) begin
                    inc = 1;
`ifdef STREAK_BONUS_EN
                    m_streak++;
                    if (m_streak == 4) begin inc = 2; m_streak = 0; end
`endif
                    m_score = (m_score + inc > 255) ? 255 : m_score + inc;
                    m_hitp = 1;
                    m_vld  = 0;
                end
                if (miss) begin
                    m_lives--;
                    m_missp  = 1;
                    m_streak = 0;
                    if (wrap) m_vld = 0;
                end
                if (smp) begin m_target = int'(rand_cell); m_vld = 1; end
                if (m_lives == 0) begin m_state = 2; m_vld = 0; end
            end else if (start) begin
                m_state = 1; m_score = 0; m_lives = LIVES_INIT; m_nivel = 1;
                m_vld = 0; m_streak = 0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("state",      32'(state),      32'(m_state));
            chk("score",      32'(score),      32'(m_score));
            chk("lives",      32'(lives),      32'(m_lives));
            chk("nivel",      32'(nivel),      32'(m_nivel));
            chk("target_vld", 32'(target_vld), 32'(m_vld));
            chk("hit_pulse",  32'(hit_pulse),  32'(m_hitp));
            chk("miss_pulse", 32'(miss_pulse), 32'(m_missp));
            if (m_vld != 0) chk("target", 32'(target), 32'(m_target));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Period wrap; two further cycles let the delayed sample land.
    task automatic wrap_cycle();
        nanos = 28'd0;
        tick();
        nanos = 28'd5;
        tick();
        tick();
    endtask

    task automatic arm(input logic [3:0] c);
        rand_cell = c;
        wrap_cycle();
    endtask

    task automatic press(input logic [3:0] c);
        btn_hit  = 1'b1;
        btn_cell = c;
        tick();
        btn_hit  = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    int exp_s5, exp_4hit, exp_mix, exp_40;

    initial begin
`ifdef STREAK_BONUS_EN
        exp_s5 = 6; exp_4hit = 5; exp_mix = 7; exp_40 = 50;
`else
        exp_s5 = 5; exp_4hit = 4; exp_mix = 6; exp_40 = 40;
`endif
        reset = 1'b0; nanos = 28'd5; rand_cell = 4'd0;
        start = 1'b0; btn_hit = 1'b0; btn_cell = 4'd0;
        tick();
        chk_en = 1;
        tick();
        reset = 1'b1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_nivel", 32'(nivel), 32'd1);
        chk("rst_lives", 32'(lives), 32'd0);

        // Reset aborts a running game
        do_start();
        for (int i = 0; i < 5; i++) begin arm(4'(i + 1)); press(4'(i + 1)); end
        tick();
        chk("pre_rst_score", 32'(score), 32'(exp_s5));
        do_reset();
        chk("mid_rst_state", 32'(state), 32'd0);
        chk("mid_rst_score", 32'(score), 32'd0);
        chk("mid_rst_nivel", 32'(nivel), 32'd1);
        chk("mid_rst_vld",   32'(target_vld), 32'd0);

        // Sample two cycles after wrap, then a correct hit
        do_start();
        chk("start_lives", 32'(lives), 32'd3);
        arm(4'hA);
        chk("sample_target", 32'(target), 32'hA);
        chk("sample_vld",    32'(target_vld), 32'd1);
        press(4'hA);
        chk("hit_score", 32'(score), 32'd1);
        chk("hit_pulse1", 32'(hit_pulse), 32'd1);
        chk("hit_vld",   32'(target_vld), 32'd0);

        // Timeouts drain lives into OVER
        arm(4'h3);
        wrap_cycle();
        chk("tmo_lives2", 32'(lives), 32'd2);
        wrap_cycle();
        chk("tmo_lives1", 32'(lives), 32'd1);
        wrap_cycle();
        chk("tmo_lives0", 32'(lives), 32'd0);
        chk("tmo_over",   32'(state), 32'd2);
        press(4'h3);
        tick();

        // Same-cycle wrap with wrong and with correct cell
        do_start();
        arm(4'h3);
        nanos = 28'd0; btn_hit = 1'b1; btn_cell = 4'h5;
        tick();
        nanos = 28'd5; btn_hit = 1'b0;
        chk("wrong_wrap_miss", 32'(miss_pulse), 32'd1);
        tick();
        tick();
        chk("wrong_wrap_lives", 32'(lives), 32'd2);
        do_start();
        nanos = 28'd0; btn_hit = 1'b1; btn_cell = 4'h3;
        tick();
        nanos = 28'd5; btn_hit = 1'b0;
        tick();
        tick();
        chk("hit_wrap_score", 32'(score), 32'd1);
        chk("hit_wrap_lives", 32'(lives), 32'd2);

        // Streak sequences
        do_reset();
        do_start();
        for (int i = 0; i < 4; i++) begin arm(4'h1); press(4'h1); end
        tick();
        chk("four_hits", 32'(score), 32'(exp_4hit));
        do_reset();
        do_start();
        arm(4'h1); press(4'h1);
        arm(4'h1); press(4'h1);
        arm(4'h3); press(4'h5); press(4'h3);
        for (int i = 0; i < 3; i++) begin arm(4'h2); press(4'h2); end
        tick();
        chk("mix_hits", 32'(score), 32'(exp_mix));
        chk("mix_lives", 32'(lives), 32'd2);

        // Level progression and score saturation
        do_reset();
        do_start();
        for (int i = 1; i <= 260; i++) begin
            arm(4'(i));
            press(4'(i));
            tick();
            if (i == 8)  chk("lvl_at_8", 32'(nivel), 32'd2);
            if (i == 40) begin
                chk("lvl_at_40",   32'(nivel), 32'd5);
                chk("score_at_40", 32'(score), 32'(exp_40));
            end
        end
        chk("score_sat", 32'(score), 32'd255);
        chk("lvl_sat",   32'(nivel), 32'd5);
        tick();
        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
